// File: rtl/config_pkg.sv
// Shared types and default sizing for the tile configuration chain and its loader.
package config_pkg;

  localparam int FRAME_BITS_DEF = 7;
  localparam int CNT_W_DEF      = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_COMMIT = 3'd3,
    ST_DONE   = 3'd4
  } cfg_ld_state_t;

  // Counter width able to index n positions; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/config_readback_chk.sv
// Readback checker: keeps the previously shifted frame and compares it with the
// bits returned from the chain while the next frame is shifted in.
module config_readback_chk
  import config_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic shift_en,
  input  logic shift_bit,
  input  logic ret_bit,
  input  logic frame_end,
  output logic err
);

  logic [FRAME_BITS-1:0] hist_reg;
  logic [FRAME_BITS-1:0] hist_next;
  logic                  have_prev_reg;
  logic                  err_reg;
  logic                  mismatch;

  // The history rotates in step with the chain: its bit 0 is always the previous
  // frame's bit at the index now returning, and after a full frame it holds the
  // frame just sent.
  assign hist_next = (hist_reg >> 1) | (FRAME_BITS'(shift_bit) << (FRAME_BITS - 1));
  assign mismatch  = shift_en && have_prev_reg && (ret_bit != hist_reg[0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_reg      <= '0;
      have_prev_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else if (clr) begin
      have_prev_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      if (shift_en) begin
        hist_reg <= hist_next;
      end
      if (frame_end) begin
        have_prev_reg <= 1'b1;
      end
      if (mismatch) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;

endmodule

// File: rtl/config_loader.sv
// Configuration frame loader: serializes frames LSB-first onto a tile shift chain
// and strobes a soft or hard commit after each. Readback checking: CONFIG_LOADER_READBACK_EN.
module config_loader
  import config_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  hard,
  input  logic [CNT_W-1:0]      num_frames,
  input  logic [FRAME_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  cfg_shift_en,
  output logic                  cfg_shift_data,
  output logic                  set_soft,
  output logic                  set_hard,
  input  logic                  cfg_shift_ret,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BIT_W = cnt_width(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

  cfg_ld_state_t         state_reg;
  cfg_ld_state_t         state_next;
  logic [FRAME_BITS-1:0] sreg_reg;
  logic [BIT_W-1:0]      bit_cnt_reg;
  logic [CNT_W-1:0]      frame_cnt_reg;
  logic [CNT_W-1:0]      frame_cnt_inc;
  logic [CNT_W-1:0]      num_frames_reg;
  logic                  hard_reg;
  logic                  start_acc;
  logic                  frame_acc;

  assign start_acc     = (state_reg == ST_IDLE) && start;
  assign frame_acc     = (state_reg == ST_FETCH) && in_valid;
  assign frame_cnt_inc = frame_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = (num_frames == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (in_valid) begin
          state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt_reg == LAST_BIT) begin
          state_next = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        state_next = (frame_cnt_inc == num_frames_reg) ? ST_DONE : ST_FETCH;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Outputs depend only on state and registered data, never directly on inputs.
  always_comb begin
    in_ready       = 1'b0;
    cfg_shift_en   = 1'b0;
    cfg_shift_data = 1'b0;
    set_soft       = 1'b0;
    set_hard       = 1'b0;
    busy           = (state_reg != ST_IDLE);
    done           = 1'b0;
    case (state_reg)
      ST_FETCH:  in_ready = 1'b1;
      ST_SHIFT: begin
        cfg_shift_en   = 1'b1;
        cfg_shift_data = sreg_reg[0];
      end
      ST_COMMIT: begin
        set_hard = hard_reg;
        set_soft = ~hard_reg;
      end
      ST_DONE:   done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_reg       <= '0;
      bit_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
      num_frames_reg <= '0;
      hard_reg       <= 1'b0;
    end else begin
      if (start_acc) begin
        hard_reg       <= hard;
        num_frames_reg <= num_frames;
        frame_cnt_reg  <= '0;
      end
      if (frame_acc) begin
        sreg_reg    <= in_data;
        bit_cnt_reg <= '0;
      end
      if (state_reg == ST_SHIFT) begin
        sreg_reg    <= sreg_reg >> 1;
        bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
      end
      if (state_reg == ST_COMMIT) begin
        frame_cnt_reg <= frame_cnt_inc;
      end
    end
  end

`ifdef CONFIG_LOADER_READBACK_EN
  config_readback_chk #(
    .FRAME_BITS(FRAME_BITS)
  ) u_readback_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (start_acc),
    .shift_en  (state_reg == ST_SHIFT),
    .shift_bit (sreg_reg[0]),
    .ret_bit   (cfg_shift_ret),
    .frame_end (state_reg == ST_COMMIT),
    .err       (err)
  );
`else
  logic unused_ret;
  assign unused_ret = cfg_shift_ret;
  assign err        = 1'b0;
`endif

endmodule

// File: tb/tb_config_loader.sv
// Self-checking bench for config_loader: random and directed loads against a
// frame-level model, with a model chain looping bits back for readback.
module tb_config_loader;

  localparam int FB = 7;
`ifdef CONFIG_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          hard;
  logic [15:0]   num_frames;
  logic [FB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          cfg_shift_en;
  logic          cfg_shift_data;
  logic          set_soft;
  logic          set_hard;
  logic          cfg_shift_ret;
  logic          busy;
  logic          done;
  logic          err;

  config_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .hard           (hard),
    .num_frames     (num_frames),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .cfg_shift_en   (cfg_shift_en),
    .cfg_shift_data (cfg_shift_data),
    .set_soft       (set_soft),
    .set_hard       (set_hard),
    .cfg_shift_ret  (cfg_shift_ret),
    .busy           (busy),
    .done           (done),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model chain: shifts in at the top, returns bit 0; flip corrupts the return path.
  logic [FB-1:0] chain;
  logic          flip;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '0;
    else if (cfg_shift_en) chain <= {cfg_shift_data, chain[FB-1:1]};
  end
  assign cfg_shift_ret = chain[0] ^ flip;

  int n_hard = 0, n_soft = 0, n_done = 0, n_rdy = 0;
  always @(negedge clk) begin
    if (set_hard) n_hard <= n_hard + 1;
    if (set_soft) n_soft <= n_soft + 1;
    if (done)     n_done <= n_done + 1;
    if (in_ready) n_rdy  <= n_rdy + 1;
  end

  int            n_cmp = 0;
  int            n_bad = 0;
  bit            use_plan;
  logic [FB-1:0] plan [0:7];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {in_ready, cfg_shift_en, cfg_shift_data, set_soft,
                         set_hard, busy, done, err}, 0);
  endtask

  // One complete load. stall<0: random 0..3 stall cycles before each frame;
  // otherwise that many stall cycles before every frame after the first.
  task automatic run_load(input bit h, input int n, input int stall, input bit ign,
                          input int flip_f, input int flip_b);
    int            hb, sb, db, rb, ns;
    logic [FB-1:0] d;
    bit            err_exp;
    hb = n_hard; sb = n_soft; db = n_done; rb = n_rdy;
    err_exp = 1'b0;
    start = 1'b1; hard = h; num_frames = 16'(n);
    step();
    start = 1'b0; hard = 1'($urandom); num_frames = 16'($urandom);
    chk("busy_after_start", busy, 1);
    chk("err_cleared", err, 0);
    if (n == 0) chk("zero_done", done, 1);
    for (int f = 0; f < n; f++) begin
      ns = (stall < 0) ? int'($urandom_range(0, 3)) : ((f == 0) ? 0 : stall);
      for (int s = 0; s < ns; s++) begin
        chk($sformatf("stall_f%0d_en", f), cfg_shift_en, 0);
        chk($sformatf("stall_f%0d_rdy", f), in_ready, 1);
        step();
      end
      chk($sformatf("fetch_f%0d_rdy", f), in_ready, 1);
      d = use_plan ? plan[f] : FB'($urandom);
      in_data = d; in_valid = 1'b1;
      step();
      in_valid = 1'b0; in_data = FB'($urandom);
      for (int i = 0; i < FB; i++) begin
        chk($sformatf("f%0d_b%0d_en_rdy", f, i), {cfg_shift_en, in_ready}, 2'b10);
        chk($sformatf("f%0d_b%0d_data", f, i), cfg_shift_data, d[i]);
        chk($sformatf("f%0d_b%0d_err", f, i), err, err_exp);
        if (ign && f == 0 && i == 3) begin
          start = 1'b1; hard = ~h; num_frames = 16'd5;
        end
        if (f == flip_f && i == flip_b) flip = 1'b1;
        step();
        start = 1'b0; flip = 1'b0;
        if (RB && f >= 1 && f == flip_f && i == flip_b) err_exp = 1'b1;
      end
      chk($sformatf("f%0d_commit", f), {set_hard, set_soft}, {h, ~h});
      chk($sformatf("f%0d_commit_err", f), err, err_exp);
      step();
    end
    if (n > 0) chk("done_pulse", done, 1);
    step();
    chk("idle_after_done", {busy, done, in_ready}, 0);
    chk("err_after_load", err, err_exp);
    chk("hard_commits", n_hard - hb, h ? n : 0);
    chk("soft_commits", n_soft - sb, h ? 0 : n);
    chk("done_count", n_done - db, 1);
    if (n == 0) chk("zero_no_ready", n_rdy - rb, 0);
    $display("load hard=%0d frames=%0d ign=%0d flip=%0d/%0d err=%0b", h, n, ign, flip_f, flip_b, err);
  endtask

  initial begin
    int hb, sb;
    rst_n = 1'b0; start = 1'b0; hard = 1'b0; num_frames = '0;
    in_data = '0; in_valid = 1'b0; flip = 1'b0; use_plan = 1'b0;
    step(); step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();
    chk_all_zero("idle");

    // Single soft frame 1010101.
    use_plan = 1'b1; plan[0] = 7'b1010101;
    run_load(1'b0, 1, 0, 1'b0, -1, -1);
    // Two hard frames with a 5-cycle stall before the second.
    use_plan = 1'b0;
    run_load(1'b1, 2, 5, 1'b0, -1, -1);
    // Zero frames.
    run_load(1'b0, 0, 0, 1'b0, -1, -1);
    // Start pulsed with toggled mode during frame 1 of 3.
    run_load(1'b1, 3, -1, 1'b1, -1, -1);
    run_load(1'b0, 3, -1, 1'b1, -1, -1);
    // Random loads.
    for (int k = 0; k < 6; k++) begin
      run_load(1'($urandom), int'($urandom_range(1, 4)), -1, 1'b0, -1, -1);
    end

    // Readback: clean loopback, then a flipped return bit, then a fresh start.
    use_plan = 1'b1; plan[0] = 7'h55; plan[1] = 7'h2A;
    run_load(1'b0, 2, 0, 1'b0, -1, -1);
    use_plan = 1'b0;
    run_load(1'b1, 3, -1, 1'b0, 1, 2);
    run_load(1'b0, 1, 0, 1'b0, -1, -1);

    // Reset on the third bit of a frame.
    hb = n_hard; sb = n_soft;
    start = 1'b1; hard = 1'b0; num_frames = 16'd1;
    step();
    start = 1'b0; in_data = 7'h5B; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("pre_reset_shift", cfg_shift_en, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_shift_reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) step();
    chk_all_zero("post_reset_idle");
    chk("post_reset_no_strobe", (n_hard - hb) + (n_soft - sb), 0);
    $display("reset mid-shift busy=%0b", busy);
    run_load(1'b1, 1, 0, 1'b0, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/config_loader.md
# config_loader

Bitstream loader that drives one tile configuration shift chain from the fabric's configuration controller. It accepts configuration frames over a valid/ready word interface, serializes each frame LSB-first onto the chain's serial input, and pulses the soft or hard commit strobe after every frame. An optional readback checker compares the bits returned from the chain's serial output against the previously sent frame.

## Interface
- `FRAME_BITS`, 7: bits per frame; this is the chain length between commits.
- `CNT_W`, 16: width of the frame-count input and of the internal frame counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a load; sampled only in IDLE.
- `hard` input 1: commit mode, latched on an accepted `start`; 1 selects `set_hard`, 0 selects `set_soft`.
- `num_frames` input CNT_W: number of frames to load, latched on an accepted `start`.
- `in_data` input FRAME_BITS: frame bits; bit 0 is shifted first.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: loader accepts a frame this cycle.
- `cfg_shift_en` output 1: chain shifts this cycle; the chain holds its contents when this is low.
- `cfg_shift_data` output 1: serial data to the chain's soft shift input.
- `set_soft` output 1: one-cycle soft commit strobe.
- `set_hard` output 1: one-cycle hard commit strobe.
- `cfg_shift_ret` input 1: chain serial output. Used only under `CONFIG_LOADER_READBACK_EN`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse when a load completes.
- `err` output 1: sticky readback mismatch flag. Tied to 0 without `CONFIG_LOADER_READBACK_EN`.

## Operation
- States: IDLE, FETCH, SHIFT, COMMIT, DONE.
- IDLE:
  - On `start=1`, latch `hard` and `num_frames`, clear the frame counter and `err`.
  - If the latched `num_frames` is 0, go to DONE; otherwise go to FETCH.
- FETCH:
  - `in_ready=1`.
  - On `in_valid & in_ready`, load the shift register from `in_data`, clear the bit counter, and go to SHIFT.
  - Stalls indefinitely while `in_valid=0`. The chain is not shifted during a stall.
- SHIFT:
  - `cfg_shift_en=1` and `cfg_shift_data=sreg[0]`. Each cycle the shift register moves right one bit and the bit counter increments.
  - After FRAME_BITS cycles, go to COMMIT.
- COMMIT:
  - Assert exactly one of `set_hard`/`set_soft`, selected by the latched mode, for one cycle. Increment the frame counter.
  - If the incremented count equals `num_frames`, go to DONE; otherwise go to FETCH.
- DONE: `done=1` for one cycle, then go to IDLE.
- `start` outside IDLE is ignored.
- `hard` and `num_frames` are not re-sampled until the next accepted `start`.
- `in_ready` is 0 in every state except FETCH. `cfg_shift_en` is 0 in every state except SHIFT.
- The frame counter wraps at CNT_W bits. The maximum load is 2^CNT_W−1 frames.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`, `cfg_shift_en`, `cfg_shift_data`, `set_soft`, `set_hard`, `busy`, `done` and `err` are all 0.
  - Shift register and counters are 0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- `start` at cycle t gives `busy=1` at t+1, in FETCH.
- A frame accepted at cycle t:
  - bit 0 is on `cfg_shift_data` with `cfg_shift_en=1` at t+1;
  - the last bit is at t+FRAME_BITS;
  - the commit strobe is at t+FRAME_BITS+1.
- Per-frame cost is FRAME_BITS+2 cycles with back-to-back `in_valid`.
- `done` pulses one cycle after the final COMMIT.
- `num_frames=0`: `done` is at t+1 after `start`. No strobes and no handshakes occur.
- Assertion of `rst_n` mid-load returns the block to IDLE immediately and forces all outputs to 0. A partially shifted frame is abandoned and no commit is issued.

## Configuration
- Macro `CONFIG_LOADER_READBACK_EN`.
- With the macro defined:
  - While in SHIFT for frame k≥1, compare `cfg_shift_ret` each cycle against the bit of frame k−1 at the same index. Frame k−1 is held in a FRAME_BITS history register.
  - Any mismatch sets `err`, which holds until the next accepted `start` or reset.
  - Frame 0 returns are not checked.
- Without the macro: no history register is built, `cfg_shift_ret` is unused, and `err` is constant 0.

## Structure
- Shared package `config_pkg`:
  - state enum `cfg_ld_state_t`;
  - default localparams for FRAME_BITS and CNT_W, shared with the tile config block.
- Sub-module `config_readback_chk`: the history register plus comparator. It is instantiated only under the macro.

## Test plan
- Reset mid-SHIFT:
  - Stimulus: assert `rst_n=0` on the third bit of a frame.
  - Response: all outputs are 0 within the same cycle. After release, the block is in IDLE with no strobe.
- Single frame, soft commit:
  - Stimulus: `num_frames=1`, `hard=0`, `in_data=7'b1010101`.
  - Response: `cfg_shift_data` reads 1,0,1,0,1,0,1 over 7 cycles with `cfg_shift_en=1`, then `set_soft` for 1 cycle, then `done` for 1 cycle.
- Hard commit with stalls:
  - Stimulus: `num_frames=2`, `hard=1`, `in_valid` held low 5 cycles before frame 2.
  - Response: `cfg_shift_en` stays 0 during the stall, `set_hard` pulses twice, and `set_soft` never asserts.
- Zero frames:
  - Stimulus: `start` with `num_frames=0`.
  - Response: `done` one cycle later, `in_ready` never asserted.
- Ignored start:
  - Stimulus: pulse `start` with `hard` toggled during frame 1 of 3.
  - Response: exactly 3 commits, all of the originally latched type.
- Readback (macro on):
  - Stimulus: feed frames 7'h55 then 7'h2A. Loop the returned bits back from a model chain, then flip one return bit.
  - Response: `err=0` while the loopback is clean. `err=1` and sticky after the flipped bit. `err` clears on the next `start`.
